rv_commit_trace_buffer: RTL

//  Synthesizable commit-trace capture for the RV32I core. Records one entry per retired

---
 rtl/rv_trace_pkg.sv | 25 ++
 rtl/rv_trace_ram.sv | 18 +
 rtl/rv_commit_trace_buffer.sv | 99 +++++++++
 3 files changed

// File: rtl/rv_trace_pkg.sv
// rv_trace_pkg: state/mode encodings and record layout helpers for the commit trace buffer
package rv_trace_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_STOP_FULL = 2'd1;
  localparam logic [1:0] MODE_TRIGGER = 2'd2;
  function automatic int rec_w(input int xlen);
    return 2 * xlen + 38;
  endfunction
  function automatic int rec_wdata_lsb(input int xlen);
    return (xlen > 0) ? 1 : 1;
  endfunction
  function automatic int rec_rd_lsb(input int xlen);
    return xlen + 1;
  endfunction
  function automatic int rec_inst_lsb(input int xlen);
    return xlen + 6;
  endfunction
  function automatic int rec_pc_lsb(input int xlen);
    return xlen + 38;
  endfunction
endpackage

// File: rtl/rv_trace_ram.sv
// rv_trace_ram: DEPTH x W storage, one synchronous write port, one asynchronous read port
module rv_trace_ram #(
  parameter int W = 102,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/rv_commit_trace_buffer.sv
// rv_commit_trace_buffer: circular capture of retired instructions with wrap/stop-full/trigger modes
module rv_commit_trace_buffer
  import rv_trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_valid,
  input  logic [XLEN-1:0]      cap_pc,
  input  logic [31:0]          cap_inst,
  input  logic [4:0]           cap_rd,
  input  logic [XLEN-1:0]      cap_wdata,
  input  logic                 cap_we,
  input  logic [1:0]           cfg_mode,
  input  logic [XLEN-1:0]      cfg_trig_pc,
  input  logic [CW-1:0]        cfg_post,
  input  logic                 arm,
  input  logic                 stop,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [2*XLEN+37:0]   rd_data,
  output logic                 rd_last,
  output logic [CW-1:0]        count,
  output logic                 overflow,
  output logic [1:0]           state
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = rec_w(XLEN);
  logic [1:0] st, mode;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, post, post_cfg;
  logic [XLEN-1:0] trig;
  logic ovf, active, wr, full, hit, fill_done, post_done, pop;
  logic [RW-1:0] ram_q;
  assign active = st == ST_CAPTURE || st == ST_POST;
  assign wr = cap_valid && active;
  assign full = cnt == CW'(DEPTH);
  assign hit = st == ST_CAPTURE && mode == MODE_TRIGGER && cap_pc == trig;
  assign fill_done = mode == MODE_STOP_FULL && cnt == CW'(DEPTH - 1);
  assign post_done = st == ST_POST && post == CW'(1);
  assign pop = rd_valid && rd_ready;
  rv_trace_ram #(.W(RW), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(wr && !arm),
    .waddr(wr_ptr),
    .wdata({cap_pc, cap_inst, cap_rd, cap_wdata, cap_we}),
    .raddr(rd_ptr),
    .rdata(ram_q)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= ST_IDLE;
      mode <= MODE_WRAP;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      post <= '0;
      post_cfg <= '0;
      trig <= '0;
      ovf <= 1'b0;
    end else if (arm) begin
      st <= ST_CAPTURE;
      mode <= cfg_mode;
      trig <= cfg_trig_pc;
      post_cfg <= cfg_post;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) begin
          rd_ptr <= rd_ptr + 1'b1;
          ovf <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end
      if (wr && hit) post <= post_cfg;
      else if (wr && st == ST_POST) post <= post - 1'b1;
      // stop wins over entering POST; the same-cycle capture is still recorded above
      if (active && (stop || (wr && (fill_done || post_done || (hit && post_cfg == '0)))))
        st <= ST_DONE;
      else if (wr && hit) st <= ST_POST;
    end
  end
  assign rd_valid = st == ST_DONE && cnt != '0;
  assign rd_data = rd_valid ? ram_q : '0;
  assign rd_last = rd_valid && cnt == CW'(1);
  assign count = cnt;
  assign overflow = ovf;
  assign state = st;
endmodule
